// File: rtl/bf_loop_stack_if.sv
// Command/status bundle between the BF control FSM and the loop-control block.
// The master side issues stack and skip commands. The slave side (bf_loop_stack)
// returns the registered stack and skip status.
interface bf_loop_stack_if #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 8,
    parameter int PTR_W  = 5
);
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] push_addr;
    logic              skip_start;
    logic              skip_open;
    logic              skip_close;
    logic              clear_err;
    logic [ADDR_W-1:0] top_addr;
    logic [PTR_W-1:0]  depth;
    logic              empty;
    logic              full;
    logic              skip_active;
    logic [CNT_W-1:0]  skip_count;
    logic              overflow;
    logic              underflow;

    modport master (
        output push, pop, push_addr, skip_start, skip_open, skip_close, clear_err,
        input  top_addr, depth, empty, full, skip_active, skip_count, overflow, underflow
    );

    modport slave (
        input  push, pop, push_addr, skip_start, skip_open, skip_close, clear_err,
        output top_addr, depth, empty, full, skip_active, skip_count, overflow, underflow
    );
endinterface

// File: rtl/bf_loop_stack.sv
// Loop-control block for the BF machine.
// A stack of loop-start PCs lets a taken ']' jump straight back to its '['.
// A nesting counter lets the control FSM skip forward over a loop whose '['
// sees a zero cell. All outputs come from registers or from decode of registers.
module bf_loop_stack #(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 8,
    parameter int PTR_W  = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    bf_loop_stack_if.slave   bus
);
    localparam int               IDX_W   = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SKIP = 1'b1
    } state_t;

    // Stack storage and registered status
    logic [ADDR_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_depth;
    logic [ADDR_W-1:0] r_top;
    state_t            r_state;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;
    logic              r_underflow;

    // Next-state decode
    logic [PTR_W-1:0]  w_depth_next;
    logic [ADDR_W-1:0] w_top_next;
    logic              w_wr_en;
    logic [IDX_W-1:0]  w_wr_idx;
    logic [IDX_W-1:0]  w_idx_m1;
    logic [IDX_W-1:0]  w_idx_m2;
    logic              w_stk_ovf;
    logic              w_stk_unf;
    state_t            w_state_next;
    logic [CNT_W-1:0]  w_count_next;
    logic              w_skip_ovf;

    // Entry indices below the top. Modulo arithmetic on the low bits stays exact
    // because these indices are only used when the depth is large enough.
    assign w_idx_m1 = r_depth[IDX_W-1:0] - IDX_W'(1);
    assign w_idx_m2 = r_depth[IDX_W-1:0] - IDX_W'(2);

    // Stack command decode. Commands are ignored while a forward skip is in progress.
    always_comb begin
        w_depth_next = r_depth;
        w_top_next   = r_top;
        w_wr_en      = 1'b0;
        w_wr_idx     = r_depth[IDX_W-1:0];
        w_stk_ovf    = 1'b0;
        w_stk_unf    = 1'b0;
        if (r_state == ST_IDLE) begin
            case ({bus.push, bus.pop})
                2'b10: begin
                    if (r_depth != DEPTH_P) begin
                        w_wr_en      = 1'b1;
                        w_wr_idx     = r_depth[IDX_W-1:0];
                        w_depth_next = r_depth + PTR_W'(1);
                        w_top_next   = bus.push_addr;
                    end else begin
                        w_stk_ovf    = 1'b1;
                    end
                end
                2'b01: begin
                    if (r_depth != PTR_W'(0)) begin
                        w_depth_next = r_depth - PTR_W'(1);
                        if (r_depth > PTR_W'(1)) begin
                            w_top_next = r_mem[w_idx_m2];
                        end else begin
                            w_top_next = {ADDR_W{1'b0}};
                        end
                    end else begin
                        w_stk_unf    = 1'b1;
                    end
                end
                2'b11: begin
                    // Replace the top in place: this is the common "pop then push" of the FSM.
                    if (r_depth != PTR_W'(0)) begin
                        w_wr_en    = 1'b1;
                        w_wr_idx   = w_idx_m1;
                        w_top_next = bus.push_addr;
                    end else begin
                        w_stk_unf  = 1'b1;
                    end
                end
                default: begin
                    w_depth_next = r_depth;
                end
            endcase
        end else begin
            w_depth_next = r_depth;
        end
    end

    // Stack entry storage. No reset, so it can map onto plain RAM. Contents are only seen through r_top.
    always_ff @(posedge clock) begin
        if (!reset && w_wr_en) begin
            r_mem[w_wr_idx] <= bus.push_addr;
        end
    end

    // Stack depth and registered top-of-stack
    always_ff @(posedge clock) begin
        if (reset) begin
            r_depth <= PTR_W'(0);
            r_top   <= {ADDR_W{1'b0}};
        end else begin
            r_depth <= w_depth_next;
            r_top   <= w_top_next;
        end
    end

    // Skip FSM next-state logic. When open and close arrive together they cancel out.
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_skip_ovf   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.skip_start) begin
                    w_state_next = ST_SKIP;
                    w_count_next = CNT_ONE;
                end else begin
                    w_count_next = r_count;
                end
            end
            ST_SKIP: begin
                if (bus.skip_open && bus.skip_close) begin
                    w_count_next = r_count;
                end else if (bus.skip_open) begin
                    if (r_count != CNT_MAX) begin
                        w_count_next = r_count + CNT_ONE;
                    end else begin
                        w_skip_ovf   = 1'b1;
                    end
                end else if (bus.skip_close) begin
                    if (r_count > CNT_ONE) begin
                        w_count_next = r_count - CNT_ONE;
                    end else begin
                        w_count_next = {CNT_W{1'b0}};
                        w_state_next = ST_IDLE;
                    end
                end else begin
                    w_count_next = r_count;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_count_next = {CNT_W{1'b0}};
            end
        endcase
    end

    // Skip FSM state and nesting-count registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_count <= {CNT_W{1'b0}};
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
        end
    end

    // Sticky error flags. A new error takes priority over clear_err in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= (r_overflow  & ~bus.clear_err) | w_stk_ovf | w_skip_ovf;
            r_underflow <= (r_underflow & ~bus.clear_err) | w_stk_unf;
        end
    end

    assign bus.top_addr    = r_top;
    assign bus.depth       = r_depth;
    assign bus.empty       = (r_depth == PTR_W'(0));
    assign bus.full        = (r_depth == DEPTH_P);
    assign bus.skip_active = (r_state == ST_SKIP);
    assign bus.skip_count  = r_count;
    assign bus.overflow    = r_overflow;
    assign bus.underflow   = r_underflow;
endmodule

// File: tb/tb_bf_loop_stack.sv
// Directed testbench for bf_loop_stack with DEPTH=4 and CNT_W=2.
// The driver applies one command per cycle and queues the hand-computed result.
// The monitor compares every output just after the following rising edge.
module tb_bf_loop_stack;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 2;
    localparam int PTR_W  = 3;

    localparam logic [6:0] C_NONE = 7'b000_0000;
    localparam logic [6:0] C_RST  = 7'b100_0000;
    localparam logic [6:0] C_PU   = 7'b010_0000;
    localparam logic [6:0] C_PO   = 7'b001_0000;
    localparam logic [6:0] C_SS   = 7'b000_1000;
    localparam logic [6:0] C_OP   = 7'b000_0100;
    localparam logic [6:0] C_CL   = 7'b000_0010;
    localparam logic [6:0] C_CE   = 7'b000_0001;

    typedef struct packed {
        logic [15:0] top;
        logic [2:0]  depth;
        logic        empty;
        logic        full;
        logic        sa;
        logic [1:0]  cnt;
        logic        ov;
        logic        un;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    bf_loop_stack_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .PTR_W(PTR_W)) bus ();

    bf_loop_stack #(
        .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .PTR_W(PTR_W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic vec(input logic [6:0] cmd, input logic [15:0] addr,
                       input logic [15:0] top, input int depth, input logic sa,
                       input int cnt, input logic ov, input logic un);
        exp_t e;
        @(negedge clock);
        reset          = cmd[6];
        bus.push       = cmd[5];
        bus.pop        = cmd[4];
        bus.skip_start = cmd[3];
        bus.skip_open  = cmd[2];
        bus.skip_close = cmd[1];
        bus.clear_err  = cmd[0];
        bus.push_addr  = addr;
        e.top   = top;
        e.depth = 3'(depth);
        e.empty = (depth == 0);
        e.full  = (depth == DEPTH);
        e.sa    = sa;
        e.cnt   = 2'(cnt);
        e.ov    = ov;
        e.un    = un;
        exp_q.push_back(e);
    endtask

    // Monitor: the outputs are valid just after each edge that follows a queued command
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {bus.top_addr, bus.depth, bus.empty, bus.full, bus.skip_active,
                     bus.skip_count, bus.overflow, bus.underflow};
                n_vec++;
                if (a !== e) begin
                    n_err++;
                    $display("FAIL vec%0d: got top=%h depth=%0d empty=%b full=%b sa=%b cnt=%0d ov=%b un=%b, want top=%h depth=%0d empty=%b full=%b sa=%b cnt=%0d ov=%b un=%b",
                             n_vec, a.top, a.depth, a.empty, a.full, a.sa, a.cnt, a.ov, a.un,
                             e.top, e.depth, e.empty, e.full, e.sa, e.cnt, e.ov, e.un);
                end
            end
        end
    end

    initial begin
        bus.push = 1'b0; bus.pop = 1'b0; bus.push_addr = 16'h0000;
        bus.skip_start = 1'b0; bus.skip_open = 1'b0; bus.skip_close = 1'b0;
        bus.clear_err = 1'b0;

        //   cmd          addr      top       dep sa cnt ov un
        vec(C_RST,       16'h0000, 16'h0000, 0, 1'b0, 0, 1'b0, 1'b0);
        vec(C_PU,        16'h0010, 16'h0010, 1, 1'b0, 0, 1'b0, 1'b0);
        vec(C_PU,        16'h0020, 16'h0020, 2, 1'b0, 0, 1'b0, 1'b0);
        vec(C_PU,        16'h0030, 16'h0030, 3, 1'b0, 0, 1'b0, 1'b0);
        vec(C_PO,        16'h0000, 16'h0020, 2, 1'b0, 0, 1'b0, 1'b0);
        vec(C_PO,        16'h0000, 16'h0010, 1, 1'b0, 0, 1'b0, 1'b0);
        vec(C_PO,        16'h0000, 16'h0000, 0, 1'b0, 0, 1'b0, 1'b0);
        vec(C_PO,        16'h0000, 16'h0000, 0, 1'b0, 0, 1'b0, 1'b1);
        vec(C_PU | C_PO, 16'h0042, 16'h0000, 0, 1'b0, 0, 1'b0, 1'b1);
        vec(C_CE,        16'h0000, 16'h0000, 0, 1'b0, 0, 1'b0, 1'b0);
        vec(C_PU,        16'h0100, 16'h0100, 1, 1'b0, 0, 1'b0, 1'b0);
        vec(C_PU | C_PO, 16'h0200, 16'h0200, 1, 1'b0, 0, 1'b0, 1'b0);
        vec(C_PU,        16'h0300, 16'h0300, 2, 1'b0, 0, 1'b0, 1'b0);
        vec(C_PU | C_PO, 16'h0400, 16'h0400, 2, 1'b0, 0, 1'b0, 1'b0);
        vec(C_PO,        16'h0000, 16'h0200, 1, 1'b0, 0, 1'b0, 1'b0);
        vec(C_RST,       16'h0000, 16'h0000, 0, 1'b0, 0, 1'b0, 1'b0);
        // Fill to DEPTH, overflow, clear_err racing a new error
        vec(C_PU,        16'h0001, 16'h0001, 1, 1'b0, 0, 1'b0, 1'b0);
        vec(C_PU,        16'h0002, 16'h0002, 2, 1'b0, 0, 1'b0, 1'b0);
        vec(C_PU,        16'h0003, 16'h0003, 3, 1'b0, 0, 1'b0, 1'b0);
        vec(C_PU,        16'h0004, 16'h0004, 4, 1'b0, 0, 1'b0, 1'b0);
        vec(C_PU,        16'h0005, 16'h0004, 4, 1'b0, 0, 1'b1, 1'b0);
        vec(C_PU | C_CE, 16'h0006, 16'h0004, 4, 1'b0, 0, 1'b1, 1'b0);
        vec(C_CE,        16'h0000, 16'h0004, 4, 1'b0, 0, 1'b0, 1'b0);
        vec(C_PO,        16'h0000, 16'h0003, 3, 1'b0, 0, 1'b0, 1'b0);
        // Skip mode: counts 1,2,3,2,1,0 with stack commands ignored
        vec(C_SS,        16'h0000, 16'h0003, 3, 1'b1, 1, 1'b0, 1'b0);
        vec(C_OP,        16'h0000, 16'h0003, 3, 1'b1, 2, 1'b0, 1'b0);
        vec(C_OP | C_PU, 16'h0077, 16'h0003, 3, 1'b1, 3, 1'b0, 1'b0);
        vec(C_CL,        16'h0000, 16'h0003, 3, 1'b1, 2, 1'b0, 1'b0);
        vec(C_CL | C_PO, 16'h0000, 16'h0003, 3, 1'b1, 1, 1'b0, 1'b0);
        vec(C_CL,        16'h0000, 16'h0003, 3, 1'b0, 0, 1'b0, 1'b0);
        // Re-entry right after exit, open+close cancel, saturation at 3
        vec(C_SS,        16'h0000, 16'h0003, 3, 1'b1, 1, 1'b0, 1'b0);
        vec(C_OP | C_CL, 16'h0000, 16'h0003, 3, 1'b1, 1, 1'b0, 1'b0);
        vec(C_OP,        16'h0000, 16'h0003, 3, 1'b1, 2, 1'b0, 1'b0);
        vec(C_OP,        16'h0000, 16'h0003, 3, 1'b1, 3, 1'b0, 1'b0);
        vec(C_OP,        16'h0000, 16'h0003, 3, 1'b1, 3, 1'b1, 1'b0);
        vec(C_SS,        16'h0000, 16'h0003, 3, 1'b1, 3, 1'b1, 1'b0);
        vec(C_OP | C_CE, 16'h0000, 16'h0003, 3, 1'b1, 3, 1'b1, 1'b0);
        vec(C_CE,        16'h0000, 16'h0003, 3, 1'b1, 3, 1'b0, 1'b0);
        // Reset during SKIP together with a push
        vec(C_RST | C_PU, 16'h0099, 16'h0000, 0, 1'b0, 0, 1'b0, 1'b0);
        vec(C_CL,        16'h0000, 16'h0000, 0, 1'b0, 0, 1'b0, 1'b0);
        vec(C_OP,        16'h0000, 16'h0000, 0, 1'b0, 0, 1'b0, 1'b0);
        vec(C_PO,        16'h0000, 16'h0000, 0, 1'b0, 0, 1'b0, 1'b1);

        @(negedge clock);
        reset = 1'b0; bus.push = 1'b0; bus.pop = 1'b0; bus.skip_start = 1'b0;
        bus.skip_open = 1'b0; bus.skip_close = 1'b0; bus.clear_err = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clock);
            #2;
        end
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d results still pending, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/bf_loop_stack.md
# bf_loop_stack

Parametrised loop-control block for the BF machine, succeeding the single 8-bit bracket counter. Holds a hardware stack of loop-start PC values, so a `]` with a non-zero cell jumps straight back to its `[` without scanning backwards. Also provides a nesting-depth skip counter for scanning forward past a loop whose `[` sees a zero cell. Sits beside the PC register and is driven by the control FSM.

## Interface
Parameters:
- ADDR_W, 16: width of stored PC values.
- DEPTH, 16: stack entries, at least 2.
- CNT_W, 8: skip-counter width.
- PTR_W, $clog2(DEPTH+1): width of `depth`.

Ports:
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- push  in  1  push `push_addr` onto the stack.
- pop  in  1  discard the top entry.
- push_addr  in  ADDR_W  PC value to push (address of the `[`).
- skip_start  in  1  enter skip mode.
- skip_open  in  1  `[` encountered while skipping.
- skip_close  in  1  `]` encountered while skipping.
- clear_err  in  1  clear the sticky error flags.
- top_addr  out  ADDR_W  top entry; 0 when empty.
- depth  out  PTR_W  number of valid entries.
- empty  out  1  depth == 0.
- full  out  1  depth == DEPTH.
- skip_active  out  1  skip mode in progress.
- skip_count  out  CNT_W  current skip nesting level.
- overflow  out  1  sticky: push while full, or skip count saturated.
- underflow  out  1  sticky: pop while empty.

## Operation
- Reset values: all outputs are 0, except `empty`, which is 1. Stack memory contents are don't-care but never visible.
- The stack and the skip counter are independent registers. While `skip_active` = 1, push and pop are ignored, with no flag and no state change.
- Stack commands, evaluated when not skipping:
  - push only, not full: entry[depth] <= push_addr; depth + 1.
  - push only, full: no change; overflow <= 1.
  - pop only, not empty: depth − 1.
  - pop only, empty: no change; underflow <= 1.
  - push and pop together, not empty: top entry replaced by push_addr; depth unchanged.
  - push and pop together, empty: no change; underflow <= 1.
- top_addr = entry[depth−1] when depth > 0, else 0. It is registered, so it is valid in the cycle after the update edge.
- Skip-mode FSM states are IDLE and SKIP. `skip_active` = (state == SKIP).
- IDLE transitions:
  - skip_start goes to SKIP with count <= 1.
  - skip_open and skip_close are ignored.
- SKIP, with inputs evaluated in this order:
  - open and close together: no change.
  - open only, count < 2^CNT_W − 1: count + 1.
  - open only, count saturated: count holds; overflow <= 1.
  - close only, count > 1: count − 1.
  - close only, count == 1: count <= 0; go to IDLE.
  - skip_start in SKIP is ignored.
- Error flags:
  - Flags are sticky until reset or clear_err.
  - clear_err in the same cycle as a new error: the new error wins (flag = 1).
- Reset asserted mid-operation, including during SKIP or together with any command: the next state is the reset state, and every command in that cycle is dropped.

## Timing
- Single-cycle latency. A command sampled at edge N is reflected on all outputs after edge N.
- No combinational path from inputs to outputs. All outputs are driven by registers or by decode of registers only.
- Back-to-back push, pop, open and close are accepted every cycle, with no busy period.
- The cycle after a close that ends skip mode shows skip_active = 0 and skip_count = 0. skip_start is accepted in that same cycle.

## Test plan
- Reset, then push 0x0010, 0x0020, 0x0030 -> depth = 3, top_addr = 0x0030. Pop -> top_addr = 0x0020, depth = 2.
- DEPTH = 4: five pushes of 0x0001..0x0005 -> full = 1, depth = 4, top_addr = 0x0004, overflow = 1. clear_err -> overflow = 0.
- From empty, pop -> underflow = 1, depth = 0, top_addr = 0. Then push+pop with addr 0x0042 from empty -> underflow stays 1, depth = 0.
- Stack holding 0x0100, then push+pop with 0x0200 -> depth = 1, top_addr = 0x0200.
- skip_start, open, open, close, close, close, on consecutive cycles -> skip_count reads 1, 2, 3, 2, 1, 0. skip_active falls after the third close. A push during SKIP is ignored (depth unchanged).
- CNT_W = 2: skip_start, then 4 opens -> count saturates at 3 and overflow = 1. Reset asserted during SKIP together with a push -> all outputs at reset values after the edge.
